// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite word memory slave with independent AW/W capture and 1-cycle reads.
// Define AXIL_SLVERR_EN to answer out-of-range word indices with SLVERR.
module axi_lite_mem_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [ADDR_WIDTH-1:0]     awaddr,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [ADDR_WIDTH-1:0]     araddr,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      rvalid,
  input  logic                      rready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFS  = $clog2(BYTES);
  localparam int IW    = $clog2(DEPTH);

  typedef enum logic {W_COLLECT, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_VALID} r_state_t;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  w_state_t              r_wstate, w_wstate_n;
  logic                  r_aw_held, w_aw_held_n;
  logic                  r_w_held, w_w_held_n;
  logic [IW-1:0]         r_aw_idx, w_aw_idx_n;
  logic                  r_aw_err, w_aw_err_n;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_n;
  logic [BYTES-1:0]      r_wstrb, w_wstrb_n;
  logic                  r_awready, w_awready_n;
  logic                  r_wready, w_wready_n;
  logic                  r_bvalid, w_bvalid_n;
  logic [1:0]            r_bresp, w_bresp_n;

  r_state_t              r_rstate, w_rstate_n;
  logic                  r_arready, w_arready_n;
  logic                  r_rvalid, w_rvalid_n;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata_n;
  logic [1:0]            r_rresp, w_rresp_n;

  logic [IW-1:0]         w_awidx, w_aridx, w_cm_idx;
  logic                  w_aw_err, w_ar_err, w_cm_err;
  logic [DATA_WIDTH-1:0] w_cm_data;
  logic [BYTES-1:0]      w_cm_strb;
  logic                  w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic                  w_unused;

  assign w_awidx = awaddr[OFFS +: IW];
  assign w_aridx = araddr[OFFS +: IW];

`ifdef AXIL_SLVERR_EN
  assign w_aw_err = |awaddr[ADDR_WIDTH-1:OFFS+IW];
  assign w_ar_err = |araddr[ADDR_WIDTH-1:OFFS+IW];
  assign w_unused = ^{awaddr[OFFS-1:0], araddr[OFFS-1:0]};
`else
  // Upper index bits drop out: the index wraps modulo DEPTH.
  assign w_aw_err = 1'b0;
  assign w_ar_err = 1'b0;
  assign w_unused = ^{awaddr[ADDR_WIDTH-1:OFFS+IW], awaddr[OFFS-1:0],
                      araddr[ADDR_WIDTH-1:OFFS+IW], araddr[OFFS-1:0]};
`endif

  assign w_aw_hs = awvalid & r_awready;
  assign w_w_hs  = wvalid & r_wready;
  assign w_ar_hs = arvalid & r_arready;

  assign w_cm_idx  = w_aw_hs ? w_awidx : r_aw_idx;
  assign w_cm_err  = w_aw_hs ? w_aw_err : r_aw_err;
  assign w_cm_data = w_w_hs ? wdata : r_wdata;
  assign w_cm_strb = w_w_hs ? wstrb : r_wstrb;
  assign w_commit  = (r_wstate == W_COLLECT) &
                     (w_aw_hs | r_aw_held) & (w_w_hs | r_w_held);

  assign awready = r_awready;
  assign wready  = r_wready;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;
  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;

  always_ff @(posedge aclk) begin
    if (w_commit && !w_cm_err) begin
      for (int i = 0; i < BYTES; i++) begin
        if (w_cm_strb[i]) r_mem[w_cm_idx][8*i +: 8] <= w_cm_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_wstate_n  = r_wstate;
    w_aw_held_n = r_aw_held;
    w_w_held_n  = r_w_held;
    w_aw_idx_n  = r_aw_idx;
    w_aw_err_n  = r_aw_err;
    w_wdata_n   = r_wdata;
    w_wstrb_n   = r_wstrb;
    w_awready_n = r_awready;
    w_wready_n  = r_wready;
    w_bvalid_n  = r_bvalid;
    w_bresp_n   = r_bresp;
    unique case (r_wstate)
      W_COLLECT: begin
        if (w_aw_hs) begin
          w_aw_held_n = 1'b1;
          w_aw_idx_n  = w_awidx;
          w_aw_err_n  = w_aw_err;
        end
        if (w_w_hs) begin
          w_w_held_n = 1'b1;
          w_wdata_n  = wdata;
          w_wstrb_n  = wstrb;
        end
        if (w_commit) begin
          w_aw_held_n = 1'b0;
          w_w_held_n  = 1'b0;
          w_awready_n = 1'b0;
          w_wready_n  = 1'b0;
          w_bvalid_n  = 1'b1;
          w_bresp_n   = w_cm_err ? 2'b10 : 2'b00;
          w_wstate_n  = W_RESP;
        end else begin
          w_awready_n = !w_aw_held_n;
          w_wready_n  = !w_w_held_n;
        end
      end
      W_RESP: begin
        if (bready) begin
          w_bvalid_n  = 1'b0;
          w_awready_n = 1'b1;
          w_wready_n  = 1'b1;
          w_wstate_n  = W_COLLECT;
        end
      end
      default: ;
    endcase
  end

  // Memory is sampled before this edge's commit lands, so a colliding
  // read returns the old word.
  always_comb begin
    w_rstate_n  = r_rstate;
    w_arready_n = r_arready;
    w_rvalid_n  = r_rvalid;
    w_rdata_n   = r_rdata;
    w_rresp_n   = r_rresp;
    unique case (r_rstate)
      R_IDLE: begin
        if (w_ar_hs) begin
          w_rdata_n   = w_ar_err ? '0 : r_mem[w_aridx];
          w_rresp_n   = w_ar_err ? 2'b10 : 2'b00;
          w_rvalid_n  = 1'b1;
          w_arready_n = 1'b0;
          w_rstate_n  = R_VALID;
        end else begin
          w_arready_n = 1'b1;
        end
      end
      R_VALID: begin
        if (rready) begin
          w_rvalid_n  = 1'b0;
          w_arready_n = 1'b1;
          w_rstate_n  = R_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wstate  <= W_COLLECT;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_aw_idx  <= '0;
      r_aw_err  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= 2'b00;
    end else begin
      r_wstate  <= w_wstate_n;
      r_aw_held <= w_aw_held_n;
      r_w_held  <= w_w_held_n;
      r_aw_idx  <= w_aw_idx_n;
      r_aw_err  <= w_aw_err_n;
      r_wdata   <= w_wdata_n;
      r_wstrb   <= w_wstrb_n;
      r_awready <= w_awready_n;
      r_wready  <= w_wready_n;
      r_bvalid  <= w_bvalid_n;
      r_bresp   <= w_bresp_n;
      r_rstate  <= w_rstate_n;
      r_arready <= w_arready_n;
      r_rvalid  <= w_rvalid_n;
      r_rdata   <= w_rdata_n;
      r_rresp   <= w_rresp_n;
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Bench for axi_lite_mem_slave: vector table, corner sequences, random traffic.
// Expectations for out-of-range accesses follow AXIL_SLVERR_EN.
module tb_axi_lite_mem_slave;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem [16];

  axi_lite_mem_slave #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(16)
  ) dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for handshake", name);
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic m_write(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [1:0] resp);
    int idx;
    idx  = int'(a >> 2);
    resp = 2'b00;
    if (idx >= 16) begin
`ifdef AXIL_SLVERR_EN
      resp = 2'b10;
      return;
`else
      idx = idx % 16;
`endif
    end
    for (int b = 0; b < 4; b++)
      if (s[b]) m_mem[idx][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic m_read(input logic [31:0] a, output logic [31:0] d,
                        output logic [1:0] resp);
    int idx;
    idx  = int'(a >> 2);
    resp = 2'b00;
    if (idx >= 16) begin
`ifdef AXIL_SLVERR_EN
      resp = 2'b10;
      d    = '0;
      return;
`else
      idx = idx % 16;
`endif
    end
    d = m_mem[idx];
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int dly,
                           output logic [1:0] resp);
    int n;
    bit aw_done, w_done, aw_go, w_go;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      cyc(); n++;
      if (aw_go) begin aw_done = 1; awvalid = 1'b0; end
      if (w_go) begin w_done = 1; wvalid = 1'b0; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) tmo("write_addr_data");
    n = 0;
    while (!bvalid && n < 20) begin cyc(); n++; end
    if (!bvalid) tmo("write_bvalid");
    repeat (dly) cyc();
    resp = bresp;
    bready = 1'b1;
    cyc();
    bready = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, input int dly,
                          output logic [31:0] d, output logic [1:0] resp);
    int n;
    bit done, go;
    araddr = a; arvalid = 1'b1; done = 0; n = 0;
    while (!done && n < 20) begin
      go = arready;
      cyc(); n++;
      if (go) done = 1;
    end
    arvalid = 1'b0;
    if (!done) tmo("read_addr");
    n = 0;
    while (!rvalid && n < 20) begin cyc(); n++; end
    if (!rvalid) tmo("read_rvalid");
    repeat (dly) cyc();
    d = rdata; resp = rresp;
    rready = 1'b1;
    cyc();
    rready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int dly);
    logic [1:0] er, r;
    m_write(a, d, s, er);
    bus_write(a, d, s, dly, r);
    chk("bresp", 32'(r), 32'(er));
  endtask

  task automatic do_read(input logic [31:0] a, input int dly,
                         output logic [31:0] d);
    logic [31:0] ed;
    logic [1:0]  er, r;
    m_read(a, ed, er);
    bus_read(a, dly, d, r);
    chk("rdata", d, ed);
    chk("rresp", 32'(r), 32'(er));
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [31:0] d;
    logic [1:0]  r, er;

    tbl[0] = '{1, 32'h24, 32'hCAFEBABE, 4'hF, 32'h0, 2'b00};
    tbl[1] = '{0, 32'h24, 32'h0, 4'h0, 32'hCAFEBABE, 2'b00};
    tbl[2] = '{1, 32'h27, 32'h11223344, 4'b1000, 32'h0, 2'b00};
    tbl[3] = '{0, 32'h25, 32'h0, 4'h0, 32'h11FEBABE, 2'b00};
    tbl[4] = '{1, 32'h28, 32'hFFFFFFFF, 4'b0000, 32'h0, 2'b00};
    tbl[5] = '{0, 32'h28, 32'h0, 4'h0, 32'h0A0A0A0A, 2'b00};
    tbl[6] = '{1, 32'h3C, 32'h12345678, 4'b0110, 32'h0, 2'b00};
    tbl[7] = '{0, 32'h3E, 32'h0, 4'h0, 32'h0F34560F, 2'b00};

    areset = 1'b1;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
    bready = 0; araddr = '0; arvalid = 0; rready = 0;
    #1;
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_valids", 32'({bvalid, rvalid}), 32'd0);
    chk("rst_resps", 32'({bresp, rresp}), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    cyc(); cyc();
    areset = 1'b0;
    cyc();
    chk("rel_readies", 32'({awready, wready, arready}), 32'b111);

    for (int i = 0; i < 16; i++)
      do_write(32'(i * 4), 32'(i) * 32'h01010101, 4'hF, 0);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].wr) begin
        m_write(tbl[i].addr, tbl[i].data, tbl[i].strb, er);
        bus_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 0, r);
        chk($sformatf("tbl%0d_bresp", i), 32'(r), 32'(tbl[i].exp_resp));
      end else begin
        bus_read(tbl[i].addr, 0, d, r);
        chk($sformatf("tbl%0d_rdata", i), d, tbl[i].exp_data);
        chk($sformatf("tbl%0d_rresp", i), 32'(r), 32'(tbl[i].exp_resp));
      end
    end

    // Same-edge AW+W, then a 6-cycle bready stall.
    chk("a_pre_ready", 32'({awready, wready}), 32'b11);
    awaddr = 32'h8; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    cyc();
    awvalid = 0; wvalid = 0;
    chk("a_bvalid", 32'(bvalid), 32'd1);
    chk("a_bresp", 32'(bresp), 32'd0);
    chk("a_readies_low", 32'({awready, wready}), 32'b00);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("a_stall_bvalid", 32'(bvalid), 32'd1);
      chk("a_stall_bresp", 32'(bresp), 32'd0);
      chk("a_stall_readies", 32'({awready, wready}), 32'b00);
    end
    bready = 1;
    cyc();
    bready = 0;
    chk("a_bvalid_clr", 32'(bvalid), 32'd0);
    chk("a_readies_back", 32'({awready, wready}), 32'b11);
    m_write(32'h8, 32'hDEADBEEF, 4'hF, er);
    araddr = 32'h8; arvalid = 1;
    cyc();
    arvalid = 0;
    chk("a_rvalid", 32'(rvalid), 32'd1);
    chk("a_rdata", rdata, 32'hDEADBEEF);
    chk("a_rresp", 32'(rresp), 32'd0);
    chk("a_arready_low", 32'(arready), 32'd0);
    cyc();
    chk("a_rdata_hold", rdata, 32'hDEADBEEF);
    chk("a_rvalid_hold", 32'(rvalid), 32'd1);
    rready = 1;
    cyc();
    rready = 0;
    chk("a_rvalid_clr", 32'(rvalid), 32'd0);
    chk("a_arready_back", 32'(arready), 32'd1);

    // W arrives two cycles ahead of AW.
    do_write(32'h4, 32'hAABBCCDD, 4'hF, 0);
    wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1;
    cyc();
    wvalid = 0;
    chk("b_wready_low", 32'(wready), 32'd0);
    chk("b_awready_hi", 32'(awready), 32'd1);
    chk("b_no_commit1", 32'(bvalid), 32'd0);
    cyc();
    chk("b_no_commit2", 32'(bvalid), 32'd0);
    awaddr = 32'h4; awvalid = 1;
    cyc();
    awvalid = 0;
    chk("b_commit", 32'(bvalid), 32'd1);
    chk("b_bresp", 32'(bresp), 32'd0);
    bready = 1;
    cyc();
    bready = 0;
    m_write(32'h4, 32'h11223344, 4'b0101, er);
    do_read(32'h4, 0, d);
    chk("b_merge", d, 32'hAA22CC44);

    // Word index 16 is out of range.
    do_write(32'h0, 32'h77777777, 4'hF, 0);
    m_write(32'h40, 32'h55, 4'hF, er);
    bus_write(32'h40, 32'h55, 4'hF, 0, r);
`ifdef AXIL_SLVERR_EN
    chk("c_bresp", 32'(r), 32'b10);
    bus_read(32'h40, 0, d, r);
    chk("c_oor_rdata", d, 32'h0);
    chk("c_oor_rresp", 32'(r), 32'b10);
    bus_read(32'h0, 0, d, r);
    chk("c_word0", d, 32'h77777777);
    chk("c_word0_rresp", 32'(r), 32'b00);
`else
    chk("c_bresp", 32'(r), 32'b00);
    bus_read(32'h0, 0, d, r);
    chk("c_word0", d, 32'h00000055);
    chk("c_word0_rresp", 32'(r), 32'b00);
`endif

    // Read and write to the same word on the same edge.
    chk("e_pre_ready", 32'({awready, wready, arready}), 32'b111);
    awaddr = 32'h8; wdata = 32'h0BADF00D; wstrb = 4'hF;
    araddr = 32'h8;
    awvalid = 1; wvalid = 1; arvalid = 1;
    cyc();
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("e_old_data", rdata, 32'hDEADBEEF);
    chk("e_bvalid", 32'(bvalid), 32'd1);
    bready = 1; rready = 1;
    cyc();
    bready = 0; rready = 0;
    m_write(32'h8, 32'h0BADF00D, 4'hF, er);
    do_read(32'h8, 0, d);

    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom_range(0, 15)),
                 int'($urandom_range(0, 2)));
      else
        do_read(a, int'($urandom_range(0, 2)), d);
    end

    // Reset between the AW and W handshakes, with a read pending.
    do_write(32'h14, 32'h5A5A5A5A, 4'hF, 0);
    araddr = 32'h14; arvalid = 1;
    cyc();
    arvalid = 0;
    chk("d_rvalid_pend", 32'(rvalid), 32'd1);
    awaddr = 32'h14; awvalid = 1;
    cyc();
    awvalid = 0;
    chk("d_aw_held", 32'({awready, wready}), 32'b01);
    areset = 1;
    #1;
    chk("d_rst_readies", 32'({awready, wready, arready}), 32'b000);
    chk("d_rst_valids", 32'({bvalid, rvalid}), 32'b00);
    chk("d_rst_rdata", rdata, 32'h0);
    cyc(); cyc();
    areset = 0;
    cyc();
    chk("d_rel_readies", 32'({awready, wready, arready}), 32'b111);
    chk("d_rel_valids", 32'({bvalid, rvalid}), 32'b00);
    cyc(); cyc(); cyc();
    chk("d_no_bresp", 32'(bvalid), 32'd0);
    do_read(32'h14, 0, d);
    chk("d_word_kept", d, 32'h5A5A5A5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
